// File: rtl/event_encoder_4to2.sv
// Clocked 4-to-2 encoder: captures request events into a pending mask and presents
// them one at a time over VALID/READY. Define ROUND_ROBIN_EN for rotating priority.
module event_encoder_4to2 #(
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       d0_i,
    input  logic       d1_i,
    input  logic       d2_i,
    input  logic       d3_i,
    input  logic       ready_i,
    output logic       a1_o,
    output logic       a0_o,
    output logic       valid_o,
    output logic [3:0] pend_o,
    output logic       ovf_o
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e     state_q;
    logic [3:0] d;
    logic [3:0] dq_q;
    logic [3:0] ev;
    logic [3:0] cap;
    logic [3:0] clr;
    logic [3:0] pend_q;
    logic [3:0] pend_d;
    logic [1:0] code_q;
    logic [1:0] sel;
    logic       ovf_q;
    logic       ovf_d;
    logic       has_pend;
    logic       load;
    logic       take;

    assign d        = {d3_i, d2_i, d1_i, d0_i};
    assign ev       = EDGE_DETECT ? (d & ~dq_q) : d;
    assign cap      = ev & {4{en_i}};
    assign has_pend = |pend_q;
    assign load     = (state_q == IDLE) || ready_i;
    assign take     = load && has_pend;
    assign clr      = take ? (4'b0001 << sel) : 4'b0000;

    // A new event on a bit being cleared this cycle re-sets it rather than overflowing.
    assign pend_d   = (pend_q & ~clr) | cap;
    assign ovf_d    = |(cap & pend_q & ~clr);

`ifdef ROUND_ROBIN_EN
    logic [1:0] ptr_q;
    logic [1:0] idx;
    logic       found;

    // Search descends from the pointer and wraps 0 -> 3.
    always_comb begin
        sel   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q - 2'(k);
            if (!found && pend_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 2'd3;
        end else if (take) begin
            ptr_q <= sel - 2'd1;
        end
    end
`else
    always_comb begin
        sel = 2'd0;
        if (pend_q[3]) begin
            sel = 2'd3;
        end else if (pend_q[2]) begin
            sel = 2'd2;
        end else if (pend_q[1]) begin
            sel = 2'd1;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            code_q  <= 2'd0;
            pend_q  <= 4'd0;
            dq_q    <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            dq_q   <= d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            if (load) begin
                if (has_pend) begin
                    code_q  <= sel;
                    state_q <= HOLD;
                end else begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign a1_o    = code_q[1];
    assign a0_o    = code_q[0];
    assign valid_o = (state_q == HOLD);
    assign pend_o  = pend_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_event_encoder_4to2.sv
// Table-driven bench for event_encoder_4to2 (edge mode), with hand-written
// reset sequences around the vector table.
module tb_event_encoder_4to2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       d0, d1, d2, d3;
    logic       ready;
    logic       a1, a0, valid, ovf;
    logic [3:0] pend;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic       en;
        logic [3:0] d;
        logic       ready;
        logic [1:0] a;
        logic       v;
        logic [3:0] p;
        logic       o;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    event_encoder_4to2 #(.EDGE_DETECT(1'b1)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .d0_i    (d0),
        .d1_i    (d1),
        .d2_i    (d2),
        .d3_i    (d3),
        .ready_i (ready),
        .a1_o    (a1),
        .a0_o    (a0),
        .valid_o (valid),
        .pend_o  (pend),
        .ovf_o   (ovf)
    );

    task automatic checkOutput(input string name, input logic [1:0] expA, input logic expV,
                               input logic [3:0] expP, input logic expO);
        testsRun++;
        if ({a1, a0} !== expA) begin
            testsFailed++;
            $display("[TB] FAIL %s code: got %b, expected %b", name, {a1, a0}, expA);
        end
        testsRun++;
        if (valid !== expV) begin
            testsFailed++;
            $display("[TB] FAIL %s valid: got %b, expected %b", name, valid, expV);
        end
        testsRun++;
        if (pend !== expP) begin
            testsFailed++;
            $display("[TB] FAIL %s pend: got %b, expected %b", name, pend, expP);
        end
        testsRun++;
        if (ovf !== expO) begin
            testsFailed++;
            $display("[TB] FAIL %s ovf: got %b, expected %b", name, ovf, expO);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [3:0] dv, input logic r);
        @(negedge clk);
        en    = e;
        {d3, d2, d1, d0} = dv;
        ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic e, input logic [3:0] dv, input logic r,
                          input logic [1:0] a, input logic v, input logic [3:0] p, input logic o);
        vec_t x;
        x.en = e; x.d = dv; x.ready = r; x.a = a; x.v = v; x.p = p; x.o = o;
        vecs.push_back(x);
    endtask

    initial begin
        logic [1:0] rrA4, rrA5;
        logic [3:0] rrP4;
`ifdef ROUND_ROBIN_EN
        rrA4 = 2'b00; rrP4 = 4'b1000; rrA5 = 2'b11;
`else
        rrA4 = 2'b11; rrP4 = 4'b0001; rrA5 = 2'b00;
`endif
        // priority: D0, D1, D3 together
        addVec(1, 4'b1011, 1, 2'b00, 0, 4'b1011, 0);
        addVec(1, 4'b0000, 1, 2'b11, 1, 4'b0011, 0);
        addVec(1, 4'b0000, 1, 2'b01, 1, 4'b0001, 0);
        addVec(1, 4'b0000, 1, 2'b00, 1, 4'b0000, 0);
        addVec(1, 4'b0000, 1, 2'b00, 0, 4'b0000, 0);
        // D3 and D0 pending, serve 11, D3 rises again before next load
        addVec(1, 4'b1001, 0, 2'b00, 0, 4'b1001, 0);
        addVec(1, 4'b0000, 0, 2'b11, 1, 4'b0001, 0);
        addVec(1, 4'b1000, 0, 2'b11, 1, 4'b1001, 0);
        addVec(1, 4'b0000, 1, rrA4,  1, rrP4,    0);
        addVec(1, 4'b0000, 1, rrA5,  1, 4'b0000, 0);
        addVec(1, 4'b0000, 1, rrA5,  0, 4'b0000, 0);
        // single D2 event
        addVec(1, 4'b0100, 1, rrA5,  0, 4'b0100, 0);
        addVec(1, 4'b0000, 1, 2'b10, 1, 4'b0000, 0);
        addVec(1, 4'b0000, 1, 2'b10, 0, 4'b0000, 0);
        // backpressure and overflow on D1
        addVec(1, 4'b0010, 0, 2'b10, 0, 4'b0010, 0);
        addVec(1, 4'b0000, 0, 2'b01, 1, 4'b0000, 0);
        addVec(1, 4'b0010, 0, 2'b01, 1, 4'b0010, 0);
        addVec(1, 4'b0000, 0, 2'b01, 1, 4'b0010, 0);
        addVec(1, 4'b0010, 0, 2'b01, 1, 4'b0010, 1);
        addVec(1, 4'b0000, 0, 2'b01, 1, 4'b0010, 0);
        addVec(1, 4'b0000, 1, 2'b01, 1, 4'b0000, 0);
        addVec(1, 4'b0000, 1, 2'b01, 0, 4'b0000, 0);
        // clear and new event on the same bit in one cycle: set wins, no overflow
        addVec(1, 4'b0010, 0, 2'b01, 0, 4'b0010, 0);
        addVec(1, 4'b0000, 0, 2'b01, 1, 4'b0000, 0);
        addVec(1, 4'b0010, 0, 2'b01, 1, 4'b0010, 0);
        addVec(1, 4'b0000, 0, 2'b01, 1, 4'b0010, 0);
        addVec(1, 4'b0010, 1, 2'b01, 1, 4'b0010, 0);
        addVec(1, 4'b0000, 1, 2'b01, 1, 4'b0000, 0);
        addVec(1, 4'b0000, 1, 2'b01, 0, 4'b0000, 0);
        // enable gating of edge capture
        addVec(0, 4'b0001, 1, 2'b01, 0, 4'b0000, 0);
        addVec(0, 4'b0000, 1, 2'b01, 0, 4'b0000, 0);
        addVec(0, 4'b0001, 1, 2'b01, 0, 4'b0000, 0);
        addVec(1, 4'b0001, 1, 2'b01, 0, 4'b0000, 0);
        addVec(1, 4'b0000, 1, 2'b01, 0, 4'b0000, 0);
        addVec(1, 4'b0001, 1, 2'b01, 0, 4'b0001, 0);
        addVec(1, 4'b0000, 1, 2'b00, 1, 4'b0000, 0);
        addVec(1, 4'b0000, 1, 2'b00, 0, 4'b0000, 0);

        // reset held with all requests high
        rst_n = 1'b0;
        en    = 1'b1;
        ready = 1'b1;
        {d3, d2, d1, d0} = 4'b1111;
        #1;
        checkOutput("reset_initial", 2'b00, 0, 4'b0000, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_held", 2'b00, 0, 4'b0000, 0);
        @(negedge clk);
        {d3, d2, d1, d0} = 4'b0000;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].d, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].a, vecs[i].v, vecs[i].p, vecs[i].o);
        end

        // asynchronous reset while a code is held and another event is pending
        applyStimulus(1, 4'b0100, 0);
        checkOutput("arst_pre1", 2'b00, 0, 4'b0100, 0);
        applyStimulus(1, 4'b0000, 0);
        checkOutput("arst_pre2", 2'b10, 1, 4'b0000, 0);
        applyStimulus(1, 4'b0001, 0);
        checkOutput("arst_pre3", 2'b10, 1, 4'b0001, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_async", 2'b00, 0, 4'b0000, 0);
        @(negedge clk);
        {d3, d2, d1, d0} = 4'b0000;
        ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 4'b0000, 1);
        checkOutput("arst_after1", 2'b00, 0, 4'b0000, 0);
        applyStimulus(1, 4'b0000, 1);
        checkOutput("arst_after2", 2'b00, 0, 4'b0000, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
